// File: rtl/quad_decoder_if.sv
// Port bundle for the quadrature decoder: encoder pins and controls toward
// the decoder, position and status back from it.
interface quad_decoder_if #(
  parameter int WIDTH = 4
);
  logic             a_in;
  logic             b_in;
  logic             clr;
  logic             err_clr;
  logic [WIDTH-1:0] cnt;
  logic             dir;
  logic             step;
  logic             err;

  modport slave (
    input  a_in, b_in, clr, err_clr,
    output cnt, dir, step, err
  );

  modport master (
    output a_in, b_in, clr, err_clr,
    input  cnt, dir, step, err
  );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises and glitch-filters an A/B encoder pair,
// then tracks a wrapping position count with step/direction/error outputs.
module quad_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYC  = 3
) (
  input logic           clk,
  input logic           rst,
  quad_decoder_if.slave io_qd
);
  localparam int            SW       = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;
  localparam logic [SW-1:0] STAB_MAX = SW'(FILTER_CYC - 1);

  logic [SYNC_STAGES-1:0] r_syncA;
  logic [SYNC_STAGES-1:0] r_syncB;
  logic [SYNC_STAGES:0]   r_vld;
  logic [1:0]             r_sPrev;
  logic [SW-1:0]          r_stab;
  logic [1:0]             r_f;
  logic [1:0]             r_prev;
  logic                   r_primed;
  logic [WIDTH-1:0]       r_cnt;
  logic                   r_dir;
  logic                   r_step;
  logic                   r_err;

  logic [1:0]    w_s;
  logic          w_sValid;
  logic          w_prevValid;
  logic [SW-1:0] w_stabNext;
  logic          w_stable;
  logic          w_change;
  logic [1:0]    w_delta;

  // Position of a pin pair along the forward cycle 00->01->11->10.
  function automatic logic [1:0] grayPos(input logic [1:0] p);
    return {p[1], p[1] ^ p[0]};
  endfunction

  // r_vld tracks pipeline fill so reset contents never count as a real sample.
  assign w_s         = {r_syncA[SYNC_STAGES-1], r_syncB[SYNC_STAGES-1]};
  assign w_sValid    = r_vld[SYNC_STAGES-1];
  assign w_prevValid = r_vld[SYNC_STAGES];

  always_comb begin
    w_stabNext = r_stab;
    if (!w_prevValid || (w_s != r_sPrev)) begin
      w_stabNext = '0;
    end else if (r_stab != STAB_MAX) begin
      w_stabNext = r_stab + 1'b1;
    end
  end

  assign w_stable = w_sValid && (w_stabNext == STAB_MAX);
  assign w_change = r_primed && (r_f != r_prev);
  assign w_delta  = grayPos(r_f) - grayPos(r_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_syncA <= '0;
      r_syncB <= '0;
      r_vld   <= '0;
      r_sPrev <= '0;
      r_stab  <= '0;
    end else begin
      r_syncA <= {r_syncA[SYNC_STAGES-2:0], io_qd.a_in};
      r_syncB <= {r_syncB[SYNC_STAGES-2:0], io_qd.b_in};
      r_vld   <= {r_vld[SYNC_STAGES-1:0], 1'b1};
      r_sPrev <= w_s;
      r_stab  <= w_stabNext;
    end
  end

  // The first stable pair after reset only primes prev, so any resting pin
  // state is accepted silently; later stable changes are decoded a cycle on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f      <= '0;
      r_prev   <= '0;
      r_primed <= 1'b0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_step   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (io_qd.err_clr) begin
        r_err <= 1'b0;
      end
      if (w_stable) begin
        r_f <= w_s;
        if (!r_primed) begin
          r_prev   <= w_s;
          r_primed <= 1'b1;
        end
      end
      if (w_change) begin
        r_prev <= r_f;
        case (w_delta)
          2'd1: begin
            r_step <= 1'b1;
            r_dir  <= 1'b1;
            r_cnt  <= r_cnt + 1'b1;
          end
          2'd3: begin
            r_step <= 1'b1;
            r_dir  <= 1'b0;
            r_cnt  <= r_cnt - 1'b1;
          end
          default: r_err <= 1'b1;
        endcase
      end
      if (io_qd.clr) begin
        r_cnt <= '0;
      end
    end
  end

  assign io_qd.cnt  = r_cnt;
  assign io_qd.dir  = r_dir;
  assign io_qd.step = r_step;
  assign io_qd.err  = r_err;
endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios plus randomized pin activity,
// checked every cycle against a run-length/queue model of the decoder.
module tb_quad_decoder;
  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
  localparam int FILT  = 3;

  logic clk = 1'b0;
  logic rst;

  quad_decoder_if #(.WIDTH(WIDTH)) qdIf ();

  quad_decoder #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC),
    .FILTER_CYC(FILT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_qd(qdIf)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nMis = 0;
  int cyc = 0;
  int dutSteps = 0;
  bit chkEn = 1'b0;

  logic [1:0]       runVal;
  int               runLen;
  bit               mPrimed;
  logic [1:0]       mAcc;
  logic [WIDTH-1:0] mCnt;
  logic             mDir;
  logic             mStep;
  logic             mErr;
  int               evDue[$];
  int               evKind[$];
  int               posOf[4] = '{0, 1, 3, 2};
  logic [1:0]       seqArr[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVec++;
    if (actual !== expected) begin
      nMis++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic modelReset();
    runLen  = 0;
    runVal  = 2'b00;
    mPrimed = 1'b0;
    mAcc    = 2'b00;
    mCnt    = '0;
    mDir    = 1'b0;
    mStep   = 1'b0;
    mErr    = 1'b0;
    evDue.delete();
    evKind.delete();
  endtask

  // One clock edge of the reference: a pin pair counts once it has been seen
  // on FILT consecutive samples; its effect appears SYNC+1 edges later.
  task automatic modelEdge(input logic [1:0] pins, input logic clrIn, input logic errClrIn, input logic rstIn);
    int  kind;
    int  due;
    bit  ill;
    if (rstIn) begin
      modelReset();
      return;
    end
    mStep = 1'b0;
    ill   = 1'b0;
    if (evDue.size() > 0 && evDue[0] == cyc) begin
      due  = evDue.pop_front();
      kind = evKind.pop_front();
      if (kind == 1) begin
        mStep = 1'b1;
        mDir  = 1'b1;
        mCnt  = mCnt + 1'b1;
      end else if (kind == 3) begin
        mStep = 1'b1;
        mDir  = 1'b0;
        mCnt  = mCnt - 1'b1;
      end else begin
        ill = 1'b1;
      end
    end
    if (clrIn) mCnt = '0;
    if (errClrIn) mErr = 1'b0;
    if (ill) mErr = 1'b1;
    if (runLen > 0 && pins == runVal) begin
      runLen++;
    end else begin
      runVal = pins;
      runLen = 1;
    end
    if (runLen >= FILT) begin
      if (!mPrimed) begin
        mPrimed = 1'b1;
        mAcc    = runVal;
      end else if (runVal != mAcc) begin
        evKind.push_back((posOf[runVal] - posOf[mAcc] + 4) % 4);
        evDue.push_back(cyc + SYNC + 1);
        mAcc = runVal;
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] pins, input logic clrIn, input logic errClrIn,
                               input logic rstIn, input int n);
    repeat (n) begin
      qdIf.a_in    = pins[1];
      qdIf.b_in    = pins[0];
      qdIf.clr     = clrIn;
      qdIf.err_clr = errClrIn;
      rst          = rstIn;
      @(posedge clk);
      modelEdge(pins, clrIn, errClrIn, rstIn);
      cyc++;
      @(negedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("cnt", 32'(qdIf.cnt), 32'(mCnt));
      checkOutput("dir", 32'(qdIf.dir), 32'(mDir));
      checkOutput("step", 32'(qdIf.step), 32'(mStep));
      checkOutput("err", 32'(qdIf.err), 32'(mErr));
      if (qdIf.step === 1'b1) dutSteps++;
    end
  end

  initial begin
    int         s0;
    int         lat;
    logic [1:0] curPins;
    logic [1:0] nxt;
    int         p;
    int         r;
    int         hold;

    qdIf.a_in    = 1'b1;
    qdIf.b_in    = 1'b1;
    qdIf.clr     = 1'b0;
    qdIf.err_clr = 1'b0;
    rst          = 1'b0;
    modelReset();
    #1;
    rst   = 1'b1;
    chkEn = 1'b1;

    $display("[TB] reset with pins at 11, then hold");
    applyStimulus(2'b11, 0, 0, 1, 3);
    checkOutput("resetCnt", 32'(qdIf.cnt), 0);
    checkOutput("resetErr", 32'(qdIf.err), 0);
    s0 = dutSteps;
    applyStimulus(2'b11, 0, 0, 0, 20);
    checkOutput("primeSteps", 32'(dutSteps - s0), 0);
    checkOutput("primeCnt", 32'(qdIf.cnt), 0);
    checkOutput("primeErr", 32'(qdIf.err), 0);

    $display("[TB] four forward cycles from 00");
    applyStimulus(2'b00, 0, 0, 1, 2);
    applyStimulus(2'b00, 0, 0, 0, 10);
    s0  = dutSteps;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(2'b01, 0, 0, 0, 1);
      if (qdIf.step === 1'b1 && lat == 0) lat = k;
    end
    checkOutput("latency", 32'(lat), 6);
    for (int e = 2; e <= 16; e++) begin
      applyStimulus(seqArr[e % 4], 0, 0, 0, 8);
    end
    checkOutput("fwdSteps", 32'(dutSteps - s0), 16);
    checkOutput("fwdCnt", 32'(qdIf.cnt), 0);
    checkOutput("fwdDir", 32'(qdIf.dir), 1);

    $display("[TB] single reverse edge through zero");
    s0 = dutSteps;
    applyStimulus(2'b10, 0, 0, 0, 8);
    checkOutput("revCnt", 32'(qdIf.cnt), 15);
    checkOutput("revDir", 32'(qdIf.dir), 0);
    checkOutput("revSteps", 32'(dutSteps - s0), 1);

    $display("[TB] glitch rejection and minimum pulse");
    applyStimulus(2'b00, 0, 0, 0, 8);
    s0 = dutSteps;
    applyStimulus(2'b10, 0, 0, 0, 2);
    applyStimulus(2'b00, 0, 0, 0, 8);
    checkOutput("glitchSteps", 32'(dutSteps - s0), 0);
    checkOutput("glitchCnt", 32'(qdIf.cnt), 0);
    s0 = dutSteps;
    applyStimulus(2'b10, 0, 0, 0, 3);
    applyStimulus(2'b00, 0, 0, 0, 10);
    checkOutput("pulseSteps", 32'(dutSteps - s0), 2);
    checkOutput("pulseCnt", 32'(qdIf.cnt), 0);

    $display("[TB] illegal transitions and err_clr");
    applyStimulus(2'b11, 0, 0, 0, 8);
    checkOutput("illErr", 32'(qdIf.err), 1);
    checkOutput("illCnt", 32'(qdIf.cnt), 0);
    applyStimulus(2'b00, 0, 0, 0, 5);
    applyStimulus(2'b00, 0, 1, 0, 1);
    checkOutput("setWinsErr", 32'(qdIf.err), 1);
    applyStimulus(2'b00, 0, 0, 0, 4);
    applyStimulus(2'b00, 0, 1, 0, 1);
    checkOutput("errClr", 32'(qdIf.err), 0);

    $display("[TB] clr on a decode cycle at cnt=7");
    for (int e = 1; e <= 7; e++) begin
      applyStimulus(seqArr[e % 4], 0, 0, 0, 8);
    end
    checkOutput("cnt7", 32'(qdIf.cnt), 7);
    applyStimulus(2'b00, 0, 0, 0, 5);
    applyStimulus(2'b00, 1, 0, 0, 1);
    checkOutput("clrStep", 32'(qdIf.step), 1);
    checkOutput("clrCnt", 32'(qdIf.cnt), 0);
    applyStimulus(2'b00, 0, 0, 0, 4);

    $display("[TB] reset in the middle of a transition");
    applyStimulus(2'b10, 0, 0, 0, 3);
    rst = 1'b1;
    #1;
    checkOutput("midRstCnt", 32'(qdIf.cnt), 0);
    checkOutput("midRstDir", 32'(qdIf.dir), 0);
    checkOutput("midRstStep", 32'(qdIf.step), 0);
    checkOutput("midRstErr", 32'(qdIf.err), 0);
    applyStimulus(2'b10, 0, 0, 1, 2);
    s0 = dutSteps;
    applyStimulus(2'b10, 0, 0, 0, 20);
    checkOutput("postRstSteps", 32'(dutSteps - s0), 0);
    checkOutput("postRstCnt", 32'(qdIf.cnt), 0);

    $display("[TB] randomized pin activity");
    curPins = 2'b10;
    for (int seg = 0; seg < 300; seg++) begin
      p = posOf[curPins];
      r = $urandom_range(0, 9);
      if (r < 4) nxt = seqArr[(p + 1) % 4];
      else if (r < 8) nxt = seqArr[(p + 3) % 4];
      else nxt = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 10);
      for (int c = 0; c < hold; c++) begin
        applyStimulus(nxt, ($urandom_range(0, 24) == 0), ($urandom_range(0, 14) == 0),
                      ($urandom_range(0, 299) == 0), 1);
      end
      curPins = nxt;
    end
    applyStimulus(curPins, 0, 0, 0, 12);

    chkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Receive-side counterpart to the team's up/down counter. It decodes a two-phase quadrature pair (a_in/b_in) from an external encoder into direction and step events.
- Maintains a wrapping WIDTH-bit position count, up on forward steps and down on reverse.
- Inputs are asynchronous, so the block synchronises and glitch-filters them. It flags illegal double-bit transitions with a sticky error.

Parameters:
WIDTH, 4, position counter width
SYNC_STAGES, 2, synchroniser flops per input (min 2)
FILTER_CYC, 3, consecutive stable cycles required before a new input pair is accepted (min 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
a_in  input  1  quadrature phase A, asynchronous to clk
b_in  input  1  quadrature phase B, asynchronous to clk
clr  input  1  synchronous clear of cnt
err_clr  input  1  synchronous clear of err
cnt  output  WIDTH  position count
dir  output  1  direction of last accepted step (1=up, 0=down)
step  output  1  one-cycle pulse per accepted step
err  output  1  sticky illegal-transition flag

Behaviour:
- Reset (async, rst=1):
  - cnt=0, dir=0, step=0, err=0.
  - Synchroniser flops, filter state and prev-state register are all cleared.
  - primed flag is cleared.
- Sync stage:
  - {a_in,b_in} pass through SYNC_STAGES flops each, giving pair s[1:0] = {A,B}.
- Filter:
  - Stability counter resets to 0 whenever s differs from its value on the previous cycle; otherwise it increments, saturating.
  - When the counter reaches FILTER_CYC-1 and s != f, f <= s.
  - Glitches shorter than FILTER_CYC cycles never reach f.
- Priming:
  - The first f update after reset, or the first cycle with primed=0 once stable, loads prev <= f and sets primed=1.
  - No step, no count, no error on that update, so any pin state at reset is accepted.
  - If pins sit at 00 after reset, priming occurs once stability is reached; prev=00.
- Decode (registered; evaluated when primed=1 and f != prev; prev <= f afterwards):
  - Forward sequence 00->01->11->10->00: step=1, dir=1, cnt=cnt+1.
  - Reverse sequence 00->10->11->01->00: step=1, dir=0, cnt=cnt-1.
  - Both bits changed (00<->11, 01<->10): err=1, step=0, cnt and dir unchanged.
- Wrap-around: up from 2^WIDTH-1 gives 0; down from 0 gives 2^WIDTH-1. No saturation.
- Latency: a clean edge on a_in or b_in yields step=1 and the updated cnt exactly SYNC_STAGES+FILTER_CYC+1 clocks after the first clk edge sampling the new level (6 with defaults).
- step: high for exactly one cycle per accepted step; back-to-back steps are legal as fast as the filter allows.
- clr: cnt <= 0 next edge. If a step is decoded in the same cycle, clr wins: cnt=0, but step and dir still reflect the decoded step.
- err_clr: err <= 0, unless an illegal transition is decoded in the same cycle, in which case err stays 1 (set wins).
- dir: holds its value until the next accepted step; not affected by clr.
- Reset mid-sequence: all state returns to reset values immediately. The block re-primes from the current pins; no spurious step on release.

Test Plan:
- Reset release with pins held at 11, hold 20 cycles -> step never pulses, cnt=0, err=0.
- From primed 00, drive 4 full forward cycles (16 edges, each held 8 clk) -> 16 step pulses, cnt ends 0 (wrapped once at 15->0), dir=1; each step exactly 6 clk after its edge.
- From cnt=0, one reverse edge 00->10 -> cnt=15, dir=0, one step pulse.
- 2-cycle glitch on a_in (0->1->0) -> no step, cnt unchanged. 3-cycle pulse -> accepted as one step, then its return edge gives the reverse step.
- Illegal 00->11 (both pins change together) -> err=1, cnt unchanged, step=0. Assert err_clr on the same cycle as a second illegal transition -> err stays 1. err_clr alone -> err=0.
- clr asserted on the step-decode cycle at cnt=7 -> cnt=0, step=1 that cycle. Assert rst mid-sequence with pins at 10 -> all outputs 0 immediately, no step after release.
